// File: rtl/vx_hpdcache_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vx_hpdcache_flush_sequencer
// Description : Request-side sequencer between the Vortex core memory bus and
//               the HPDCache core-interface adapter. Loads and stores pass
//               through with zero added latency while the number of in-flight
//               reads is tracked. A flush is accepted and held, all
//               outstanding read responses are drained, then exactly one
//               flush is issued downstream and its completion is forwarded
//               back to the core.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               core_req_*         - upstream request channel (valid/ready)
//               core_rsp_*         - upstream response channel (no stall)
//               mem_req_*          - downstream request channel (valid/ready)
//               mem_rsp_*          - downstream response channel (no stall)
//               flush_busy         - high whenever a flush is in progress
//               err_o              - sticky counter underflow/overflow flag
// Revision    : 1.0 - initial release
// ============================================================================
module vx_hpdcache_flush_sequencer #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 128,
   parameter int TAG_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 16
) (
   input  logic                    clk,
   input  logic                    reset,

   input  logic                    core_req_valid,
   output logic                    core_req_ready,
   input  logic                    core_req_rw,
   input  logic                    core_req_flush,
   input  logic [ADDR_WIDTH-1:0]   core_req_addr,
   input  logic [DATA_WIDTH-1:0]   core_req_data,
   input  logic [DATA_WIDTH/8-1:0] core_req_byteen,
   input  logic [TAG_WIDTH-1:0]    core_req_tag,

   output logic                    core_rsp_valid,
   output logic [DATA_WIDTH-1:0]   core_rsp_data,
   output logic [TAG_WIDTH-1:0]    core_rsp_tag,

   output logic                    mem_req_valid,
   input  logic                    mem_req_ready,
   output logic                    mem_req_rw,
   output logic                    mem_req_flush,
   output logic [ADDR_WIDTH-1:0]   mem_req_addr,
   output logic [DATA_WIDTH-1:0]   mem_req_data,
   output logic [DATA_WIDTH/8-1:0] mem_req_byteen,
   output logic [TAG_WIDTH-1:0]    mem_req_tag,

   input  logic                    mem_rsp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_rsp_data,
   input  logic [TAG_WIDTH-1:0]    mem_rsp_tag,

   output logic                    flush_busy,
   output logic                    err_o
);

   localparam int             CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ISSUE = 2'd2,
      ST_WAIT  = 2'd3
   } state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TAG_WIDTH-1:0]   flush_tag_q, flush_tag_d;
   logic                   err_q, err_d;
   logic                   flush_busy_q;

   logic                   w_is_read;
   logic                   w_cnt_full;
   logic                   w_cnt_zero;
   logic                   w_inc;
   logic                   w_dec;

   assign w_is_read  = !core_req_rw && !core_req_flush;
   assign w_cnt_full = (cnt_q == C_CNT_MAX);
   assign w_cnt_zero = (cnt_q == '0);

   // ------------------------------------------------------------------------
   // Response path: the adapter cannot be stalled, so it is a pure wire.
   // ------------------------------------------------------------------------
   assign core_rsp_valid = mem_rsp_valid;
   assign core_rsp_data  = mem_rsp_data;
   assign core_rsp_tag   = mem_rsp_tag;

   // ------------------------------------------------------------------------
   // Request path steering
   // ------------------------------------------------------------------------
   always_comb begin
      core_req_ready = 1'b0;
      mem_req_valid  = 1'b0;
      mem_req_rw     = core_req_rw;
      mem_req_flush  = 1'b0;
      mem_req_addr   = core_req_addr;
      mem_req_data   = core_req_data;
      mem_req_byteen = core_req_byteen;
      mem_req_tag    = core_req_tag;

      unique case (state_q)
         ST_IDLE: begin
            if (core_req_flush) begin
               // Flush is absorbed locally; nothing goes downstream yet.
               core_req_ready = 1'b1;
            end else if (w_is_read && w_cnt_full) begin
               // Read stalled: counter has no room for another response.
               core_req_ready = 1'b0;
            end else begin
               mem_req_valid  = core_req_valid;
               core_req_ready = mem_req_ready;
            end
         end
         ST_ISSUE: begin
            // Driven from registers only, so fields are stable until ready.
            mem_req_valid  = 1'b1;
            mem_req_flush  = 1'b1;
            mem_req_rw     = 1'b0;
            mem_req_addr   = '0;
            mem_req_data   = '0;
            mem_req_byteen = '0;
            mem_req_tag    = flush_tag_q;
         end
         default: begin
         end
      endcase

      if (reset) begin
         core_req_ready = 1'b0;
         mem_req_valid  = 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Outstanding read counter and error flag
   // ------------------------------------------------------------------------
   // Only plain reads accepted in IDLE carry a response that counts; the
   // flush completion in WAIT is deliberately excluded from the decrement.
   assign w_inc = (state_q == ST_IDLE) && mem_req_valid && mem_req_ready
                  && !mem_req_rw && !mem_req_flush;
   assign w_dec = mem_rsp_valid && ((state_q == ST_IDLE) || (state_q == ST_DRAIN));

   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;

      unique case ({w_inc, w_dec})
         2'b10: begin
            if (w_cnt_full) err_d = 1'b1;
            else            cnt_d = cnt_q + 1'b1;
         end
         2'b01: begin
            if (!w_cnt_zero) cnt_d = cnt_q - 1'b1;
         end
         default: begin
         end
      endcase

      // A response with nothing outstanding is always a protocol error,
      // even when a new read is accepted in the same cycle.
      if (w_dec && w_cnt_zero) err_d = 1'b1;
   end

   // ------------------------------------------------------------------------
   // Flush sequencing
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      flush_tag_d = flush_tag_q;

      unique case (state_q)
         ST_IDLE: begin
            if (core_req_valid && core_req_ready && core_req_flush) begin
               flush_tag_d = core_req_tag;
               state_d     = ST_DRAIN;
            end
         end
         // Looking at the next count lets ISSUE follow the last response by
         // exactly one cycle, and also covers an already-empty counter.
         ST_DRAIN: begin
            if (cnt_d == '0) state_d = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (mem_req_ready) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (mem_rsp_valid) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         flush_tag_q  <= '0;
         err_q        <= 1'b0;
         flush_busy_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         flush_tag_q  <= flush_tag_d;
         err_q        <= err_d;
         flush_busy_q <= (state_d != ST_IDLE);
      end
   end

   assign flush_busy = flush_busy_q;
   assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_vx_hpdcache_flush_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vx_hpdcache_flush_sequencer
// Description : Self-checking bench for vx_hpdcache_flush_sequencer. Expected
//               responses are queued when the matching request is driven and
//               popped by a response monitor when the core response appears.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_hpdcache_flush_sequencer;

   localparam int AW = 32;
   localparam int DW = 128;
   localparam int TW = 8;
   localparam int MO = 16;

   logic            clk;
   logic            reset;
   logic            core_req_valid;
   logic            core_req_ready;
   logic            core_req_rw;
   logic            core_req_flush;
   logic [AW-1:0]   core_req_addr;
   logic [DW-1:0]   core_req_data;
   logic [DW/8-1:0] core_req_byteen;
   logic [TW-1:0]   core_req_tag;
   logic            core_rsp_valid;
   logic [DW-1:0]   core_rsp_data;
   logic [TW-1:0]   core_rsp_tag;
   logic            mem_req_valid;
   logic            mem_req_ready;
   logic            mem_req_rw;
   logic            mem_req_flush;
   logic [AW-1:0]   mem_req_addr;
   logic [DW-1:0]   mem_req_data;
   logic [DW/8-1:0] mem_req_byteen;
   logic [TW-1:0]   mem_req_tag;
   logic            mem_rsp_valid;
   logic [DW-1:0]   mem_rsp_data;
   logic [TW-1:0]   mem_rsp_tag;
   logic            flush_busy;
   logic            err_o;

   vx_hpdcache_flush_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MO)
   ) dut (
      .clk(clk), .reset(reset),
      .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
      .core_req_rw(core_req_rw), .core_req_flush(core_req_flush),
      .core_req_addr(core_req_addr), .core_req_data(core_req_data),
      .core_req_byteen(core_req_byteen), .core_req_tag(core_req_tag),
      .core_rsp_valid(core_rsp_valid), .core_rsp_data(core_rsp_data),
      .core_rsp_tag(core_rsp_tag),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_rw(mem_req_rw), .mem_req_flush(mem_req_flush),
      .mem_req_addr(mem_req_addr), .mem_req_data(mem_req_data),
      .mem_req_byteen(mem_req_byteen), .mem_req_tag(mem_req_tag),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
      .mem_rsp_tag(mem_rsp_tag),
      .flush_busy(flush_busy), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   allow_spurious;
   int   checks;
   int   errors;

   function automatic logic [DW-1:0] rdata(input logic [TW-1:0] t);
      return {32'hDEAD_0000 | {24'h0, t}, ~{24'h0, t}, {4{t}}, 32'h1234_0000 | {24'h0, t}};
   endfunction

   // Scoreboard consumer: every core response must match the oldest entry.
   always @(negedge clk) begin
      if (core_rsp_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            if (!allow_spurious) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected got_tag=%h", core_rsp_tag);
            end
         end else begin
            mon_e = exp_q.pop_front();
            checks++;
            if (core_rsp_tag !== mon_e.tag || core_rsp_data !== mon_e.data) begin
               errors++;
               $display("FAIL rsp_match got_tag=%h exp_tag=%h got_data=%h exp_data=%h",
                        core_rsp_tag, mon_e.tag, core_rsp_data, mon_e.data);
            end
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic rw, input logic fl, input logic [TW-1:0] tag);
      core_req_valid  = 1'b1;
      core_req_rw     = rw;
      core_req_flush  = fl;
      core_req_tag    = tag;
      core_req_addr   = 32'h0000_1000 + {24'h0, tag};
      core_req_data   = ~rdata(tag);
      core_req_byteen = rw ? 16'h0F0F : 16'hFFFF;
   endtask

   task automatic send_rsp;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = exp_q[0].tag;
      mem_rsp_data  = exp_q[0].data;
      tick();
      mem_rsp_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      allow_spurious = 1'b1;
      set_req(1'b0, 1'b0, 8'h11);
      mem_req_ready = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 8'h5C;
      mem_rsp_data  = rdata(8'h5C);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_gate got_ready=%b got_valid=%b exp=0/0", core_req_ready, mem_req_valid);
      end
      checks++;
      if (flush_busy !== 1'b0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got_busy=%b got_err=%b exp=0/0", flush_busy, err_o);
      end
      checks++;
      if (core_rsp_valid !== 1'b1 || core_rsp_tag !== 8'h5C) begin
         errors++;
         $display("FAIL reset_rsp_pass got=%b/%h exp=1/5c", core_rsp_valid, core_rsp_tag);
      end
      tick();
      reset = 1'b0;
      mem_rsp_valid = 1'b0;
      core_req_valid = 1'b0;
      allow_spurious = 1'b0;
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready got=%b exp=1", core_req_ready);
      end
      tick();
   endtask

   task automatic test_passthrough;
      mem_req_ready = 1'b0;
      set_req(1'b0, 1'b0, 8'h01);
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || core_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL pass_backpressure got_valid=%b got_ready=%b exp=1/0", mem_req_valid, core_req_ready);
      end
      mem_req_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         set_req(1'b0, 1'b0, TW'(i));
         @(negedge clk);
         checks++;
         if (mem_req_valid !== 1'b1 || core_req_ready !== 1'b1 || mem_req_tag !== TW'(i)
             || mem_req_addr !== 32'h0000_1000 + i || mem_req_data !== ~rdata(TW'(i))
             || mem_req_flush !== 1'b0 || mem_req_rw !== 1'b0) begin
            errors++;
            $display("FAIL pass_fwd i=%0d got_valid=%b ready=%b tag=%h addr=%h exp_tag=%h",
                     i, mem_req_valid, core_req_ready, mem_req_tag, mem_req_addr, TW'(i));
         end
         exp_q.push_back('{tag: TW'(i), data: rdata(TW'(i))});
         tick();
      end
      core_req_valid = 1'b0;
      for (int i = 0; i < 4; i++) send_rsp();
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0) begin
         errors++;
         $display("FAIL pass_err got=%b exp=0", err_o);
      end
      tick();
   endtask

   task automatic test_flush_traffic;
      for (int i = 0; i < 3; i++) begin
         set_req(1'b0, 1'b0, 8'h10 + TW'(i));
         @(negedge clk);
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_tag !== 8'h10 + TW'(i)) begin
            errors++;
            $display("FAIL ft_read i=%0d got=%b/%h", i, mem_req_valid, mem_req_tag);
         end
         exp_q.push_back('{tag: 8'h10 + TW'(i), data: rdata(8'h10 + TW'(i))});
         tick();
      end
      set_req(1'b1, 1'b1, 8'h2A);
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL ft_accept got_ready=%b got_valid=%b exp=1/0", core_req_ready, mem_req_valid);
      end
      tick();
      // Drain: a new read is offered while responses come back one per cycle.
      for (int k = 0; k < 3; k++) begin
         set_req(1'b0, 1'b0, 8'h40);
         mem_rsp_valid = 1'b1;
         mem_rsp_tag   = exp_q[0].tag;
         mem_rsp_data  = exp_q[0].data;
         @(negedge clk);
         checks++;
         if (mem_req_valid !== 1'b0 || core_req_ready !== 1'b0 || flush_busy !== 1'b1) begin
            errors++;
            $display("FAIL ft_drain k=%0d got_valid=%b ready=%b busy=%b exp=0/0/1",
                     k, mem_req_valid, core_req_ready, flush_busy);
         end
         tick();
      end
      mem_rsp_valid  = 1'b0;
      core_req_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_flush !== 1'b1 || mem_req_tag !== 8'h2A
          || mem_req_rw !== 1'b0 || mem_req_byteen !== '0) begin
         errors++;
         $display("FAIL ft_issue got_valid=%b flush=%b tag=%h rw=%b be=%h exp=1/1/2a/0/0",
                  mem_req_valid, mem_req_flush, mem_req_tag, mem_req_rw, mem_req_byteen);
      end
      exp_q.push_back('{tag: 8'h2A, data: rdata(8'h2A)});
      tick();
      set_req(1'b0, 1'b0, 8'h41);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (core_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
            errors++;
            $display("FAIL ft_wait k=%0d got_ready=%b got_valid=%b exp=0/0", k, core_req_ready, mem_req_valid);
         end
         tick();
      end
      core_req_valid = 1'b0;
      send_rsp();
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1 || flush_busy !== 1'b0) begin
         errors++;
         $display("FAIL ft_done got_ready=%b got_busy=%b exp=1/0", core_req_ready, flush_busy);
      end
      tick();
   endtask

   task automatic test_flush_idle;
      mem_req_ready = 1'b0;
      set_req(1'b0, 1'b1, 8'h55);
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL fi_accept got=%b exp=1", core_req_ready);
      end
      tick();
      core_req_valid = 1'b0;
      core_req_flush = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0 || flush_busy !== 1'b1) begin
         errors++;
         $display("FAIL fi_t1 got_valid=%b got_busy=%b exp=0/1", mem_req_valid, flush_busy);
      end
      tick();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_flush !== 1'b1 || mem_req_tag !== 8'h55
             || mem_req_rw !== 1'b0 || mem_req_byteen !== '0) begin
            errors++;
            $display("FAIL fi_stable k=%0d got_valid=%b flush=%b tag=%h exp=1/1/55",
                     k, mem_req_valid, mem_req_flush, mem_req_tag);
         end
         tick();
      end
      mem_req_ready = 1'b1;
      exp_q.push_back('{tag: 8'h55, data: rdata(8'h55)});
      tick();
      send_rsp();
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL fi_done got=%b exp=1", core_req_ready);
      end
      tick();
   endtask

   task automatic test_counter_limits;
      for (int i = 0; i < MO; i++) begin
         set_req(1'b0, 1'b0, 8'h80 + TW'(i));
         @(negedge clk);
         checks++;
         if (mem_req_valid !== 1'b1 || core_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL cl_fill i=%0d got=%b/%b exp=1/1", i, mem_req_valid, core_req_ready);
         end
         exp_q.push_back('{tag: 8'h80 + TW'(i), data: rdata(8'h80 + TW'(i))});
         tick();
      end
      set_req(1'b0, 1'b0, 8'h90);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0 || core_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL cl_read_stall got=%b/%b exp=0/0", mem_req_valid, core_req_ready);
      end
      set_req(1'b1, 1'b0, 8'h9F);
      #1;
      checks++;
      if (mem_req_valid !== 1'b1 || core_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL cl_write_pass got=%b/%b exp=1/1", mem_req_valid, core_req_ready);
      end
      tick();
      core_req_valid = 1'b0;
      send_rsp();
      // Read accepted in the same cycle as a response: count stays at 15.
      set_req(1'b0, 1'b0, 8'h90);
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = exp_q[0].tag;
      mem_rsp_data  = exp_q[0].data;
      exp_q.push_back('{tag: 8'h90, data: rdata(8'h90)});
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || core_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL cl_simul got=%b/%b exp=1/1", mem_req_valid, core_req_ready);
      end
      tick();
      mem_rsp_valid = 1'b0;
      set_req(1'b0, 1'b0, 8'h91);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || core_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL cl_refill got=%b/%b exp=1/1", mem_req_valid, core_req_ready);
      end
      exp_q.push_back('{tag: 8'h91, data: rdata(8'h91)});
      tick();
      set_req(1'b0, 1'b0, 8'h92);
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b0 || core_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL cl_full_again got=%b/%b exp=0/0", mem_req_valid, core_req_ready);
      end
      tick();
      core_req_valid = 1'b0;
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) send_rsp();
      @(negedge clk);
      checks++;
      if (err_o !== 1'b0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL cl_drain got_err=%b pending=%0d exp=0/0", err_o, exp_q.size());
      end
      tick();
   endtask

   task automatic test_error;
      allow_spurious = 1'b1;
      mem_rsp_valid = 1'b1;
      mem_rsp_tag   = 8'hEE;
      mem_rsp_data  = rdata(8'hEE);
      @(negedge clk);
      checks++;
      if (core_rsp_valid !== 1'b1 || core_rsp_tag !== 8'hEE) begin
         errors++;
         $display("FAIL err_rsp_pass got=%b/%h exp=1/ee", core_rsp_valid, core_rsp_tag);
      end
      tick();
      mem_rsp_valid = 1'b0;
      allow_spurious = 1'b0;
      @(negedge clk);
      checks++;
      if (err_o !== 1'b1) begin
         errors++;
         $display("FAIL err_set got=%b exp=1", err_o);
      end
      repeat (3) tick();
      // Count must still be 0: an idle flush reaches ISSUE two cycles later.
      set_req(1'b0, 1'b1, 8'h66);
      tick();
      core_req_valid = 1'b0;
      core_req_flush = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tag !== 8'h66 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL err_count_zero got_valid=%b tag=%h err=%b exp=1/66/1", mem_req_valid, mem_req_tag, err_o);
      end
      exp_q.push_back('{tag: 8'h66, data: rdata(8'h66)});
      tick();
      send_rsp();
   endtask

   task automatic test_reset_mid_flush;
      for (int i = 0; i < 2; i++) begin
         set_req(1'b0, 1'b0, 8'h21 + TW'(i));
         tick();
      end
      set_req(1'b0, 1'b1, 8'h77);
      tick();
      core_req_valid = 1'b0;
      core_req_flush = 1'b0;
      @(negedge clk);
      checks++;
      if (flush_busy !== 1'b1 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_drain got_busy=%b got_valid=%b exp=1/0", flush_busy, mem_req_valid);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (core_req_ready !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_in_reset got=%b/%b exp=0/0", core_req_ready, mem_req_valid);
      end
      tick();
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1 || flush_busy !== 1'b0 || err_o !== 1'b0) begin
         errors++;
         $display("FAIL rm_drain_exit got_ready=%b busy=%b err=%b exp=1/0/0", core_req_ready, flush_busy, err_o);
      end
      mem_req_ready = 1'b0;
      #1;
      checks++;
      if (core_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rm_follow got=%b exp=0", core_req_ready);
      end
      mem_req_ready = 1'b1;
      tick();
      set_req(1'b0, 1'b1, 8'h78);
      tick();
      core_req_valid = 1'b0;
      core_req_flush = 1'b0;
      tick();
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_tag !== 8'h78) begin
         errors++;
         $display("FAIL rm_count_cleared got=%b/%h exp=1/78", mem_req_valid, mem_req_tag);
      end
      tick();
      @(negedge clk);
      checks++;
      if (flush_busy !== 1'b1 || core_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL rm_wait got_busy=%b got_ready=%b exp=1/0", flush_busy, core_req_ready);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (core_req_ready !== 1'b1 || flush_busy !== 1'b0 || mem_req_valid !== 1'b0) begin
         errors++;
         $display("FAIL rm_wait_exit got_ready=%b busy=%b valid=%b exp=1/0/0",
                  core_req_ready, flush_busy, mem_req_valid);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      allow_spurious  = 1'b0;
      reset           = 1'b1;
      core_req_valid  = 1'b0;
      core_req_rw     = 1'b0;
      core_req_flush  = 1'b0;
      core_req_addr   = '0;
      core_req_data   = '0;
      core_req_byteen = '0;
      core_req_tag    = '0;
      mem_req_ready   = 1'b1;
      mem_rsp_valid   = 1'b0;
      mem_rsp_data    = '0;
      mem_rsp_tag     = '0;

      test_reset();
      test_passthrough();
      test_flush_traffic();
      test_flush_idle();
      test_counter_limits();
      test_error();
      test_reset_mid_flush();

      repeat (2) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty got=%0d exp=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
